// File: rtl/matrix_ctrl_pkg.sv
// matrix_ctrl_pkg: shared state/operation encodings and matrix geometry for the sequencer
package matrix_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_SHOW, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_TRN} op_t;
  localparam int N_ELEM = 4;
  localparam int B_BASE = 4;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one pulse per rising edge of a synchronized level, suppressed until the level is seen low after reset
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);
  logic prev, armed;
  // armed stays low until the level has been low once, so a button held through reset never fires
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= armed | ~level;
    end
  assign pulse = level & ~prev & armed;
endmodule

// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: button-driven sequencer that loads operands, launches the datapath and steps through results
module matrix_seq_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int DONE_TIMEOUT = 255,
  parameter int ELEM_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ELEM_W-1:0] data_in,
  input  logic              enter,
  input  logic              sw,
  input  logic [1:0]        operation,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [ELEM_W-1:0] wr_data,
  output logic [1:0]        op_out,
  output logic              start,
  input  logic              done,
  input  logic              dp_error,
  output logic [1:0]        rd_addr,
  output logic              finish,
  output logic              error,
  output logic              busy,
  output logic [3:0]        index
);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  state_t        state;
  logic [1:0]    cnt;
  logic [TW-1:0] tcnt;
  logic          ev;
  rise_detect u_rise (.clock(clock), .reset(reset), .level(enter), .pulse(ev));
  // single FSM; every output is assigned on the transition so it is valid from the first cycle of the new state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tcnt    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      op_out  <= '0;
      start   <= 1'b0;
      rd_addr <= '0;
      finish  <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
      index   <= '0;
    end else begin
      wr_en <= 1'b0;
      start <= 1'b0;
      case (state)
        S_IDLE:
          if (ev) begin
            op_out <= operation;
            cnt    <= '0;
            state  <= S_LOAD_A;
            busy   <= 1'b1;
            index  <= '0;
          end
        S_LOAD_A, S_LOAD_B:
          if (sw) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            index <= '0;
          end else if (ev) begin
            wr_en   <= 1'b1;
            wr_addr <= (state == S_LOAD_B ? 3'(B_BASE) : 3'd0) + {1'b0, cnt};
            wr_data <= data_in;
            if (cnt == 2'(N_ELEM - 1)) begin
              cnt <= '0;
              if (state == S_LOAD_A && op_out != OP_TRN) begin
                state <= S_LOAD_B;
                index <= 4'(B_BASE);
              end else begin
                state <= S_START;
                start <= 1'b1;
                index <= '0;
              end
            end else begin
              cnt   <= cnt + 1'b1;
              index <= index + 1'b1;
            end
          end
        S_START: begin
          state <= S_WAIT;
          tcnt  <= '0;
        end
        S_WAIT:
          if (done) begin
            state   <= dp_error ? S_ERR : S_SHOW;
            error   <= dp_error;
            finish  <= ~dp_error;
            rd_addr <= '0;
            index   <= dp_error ? 4'd0 : 4'd8;
          end else if (tcnt == TW'(DONE_TIMEOUT - 1)) begin
            state <= S_ERR;
            error <= 1'b1;
          end else
            tcnt <= tcnt + 1'b1;
        S_SHOW:
          if (sw || (ev && rd_addr == 2'd3)) begin
            state  <= S_IDLE;
            finish <= 1'b0;
            busy   <= 1'b0;
            index  <= '0;
          end else if (ev) begin
            rd_addr <= rd_addr + 1'b1;
            index   <= index + 1'b1;
          end
        S_ERR:
          if (ev) begin
            state <= S_IDLE;
            error <= 1'b0;
            busy  <= 1'b0;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/matrix_seq_ctrl.md
MATRIX_SEQ_CTRL -- requirements
Module: matrix_seq_ctrl

Interface
REQ-001 Parameter DONE_TIMEOUT, default 255, max cycles waited for datapath done before error.
REQ-002 Parameter ELEM_W, default 8, matrix element width.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 data_in  in  ELEM_W  element value from user switches (pre-synchronized).
REQ-006 enter  in  1  user step button, synchronized level.
REQ-007 sw  in  1  abort request, synchronized level.
REQ-008 operation  in  2  00 add, 01 sub, 10 mul, 11 transpose A.
REQ-009 wr_en / wr_addr / wr_data  out  1/3/ELEM_W  datapath operand write port; addr 0-3 = A, 4-7 = B.
REQ-010 op_out  out  2  operation latched for datapath.
REQ-011 start  out  1  single-cycle compute request to datapath.
REQ-012 done / dp_error  in  1/1  datapath completion pulse and overflow flag (valid with done).
REQ-013 rd_addr  out  2  result element selected for display.
REQ-014 finish / error / busy  out  1/1/1  result showing / fault / not IDLE.
REQ-015 index  out  4  current element index shown to user.

Function
REQ-016 Enter event = enter high while previous-cycle enter low; one event per press regardless of hold length.
REQ-017 States: IDLE, LOAD_A, LOAD_B, START, WAIT, SHOW, ERR.
REQ-018 IDLE: enter event latches operation into op_out, clears element counter, goes LOAD_A.
REQ-019 LOAD_A/LOAD_B: enter event in cycle N captures data_in; wr_en=1 in cycle N+1 only, wr_addr = base + count (base 0 for A, 4 for B), wr_data = captured value.
REQ-020 Count 0-3 per matrix; event at count 3 in LOAD_A goes LOAD_B, except op_out=11 goes START (B skipped).
REQ-021 Event at count 3 in LOAD_B goes START.
REQ-022 START lasts exactly one cycle with start=1, then WAIT; timeout counter cleared on entering WAIT.
REQ-023 WAIT: done with dp_error=0 goes SHOW with rd_addr=0; done with dp_error=1 goes ERR; counter reaching DONE_TIMEOUT with no done goes ERR.
REQ-024 done and timeout in same cycle: done wins.
REQ-025 done outside WAIT is ignored.
REQ-026 SHOW: finish=1; each enter event increments rd_addr; event at rd_addr 3 goes IDLE (no wrap to 0).
REQ-027 ERR: error=1; enter event goes IDLE and clears error.
REQ-028 sw high in LOAD_A, LOAD_B or SHOW goes IDLE next cycle; sw overrides a simultaneous enter event (no write issued); sw ignored in START/WAIT/ERR.
REQ-029 index: LOAD_A = count, LOAD_B = 4+count, SHOW = 8+rd_addr, else 0.
REQ-030 busy=1 in every state except IDLE.
REQ-031 All outputs registered; no combinational input-to-output path.

Reset
REQ-032 Reset asserted at any time, including mid-load or WAIT, returns to IDLE asynchronously with no further wr_en or start.
REQ-033 Reset values: wr_en=0, wr_addr=0, wr_data=0, op_out=00, start=0, rd_addr=0, finish=0, error=0, busy=0, index=0; counters and previous-enter register cleared.
REQ-034 enter held high through reset release produces no event until it falls and rises again.

Structure
REQ-035 Package matrix_ctrl_pkg holds state enum, operation enum (OP_ADD, OP_SUB, OP_MUL, OP_TRN), N_ELEM=4 and B_BASE=4.
REQ-036 One sub-module, rise_detect, supplies the enter event; everything else in matrix_seq_ctrl.

Verification
REQ-037 Add flow: op=00, 9 presses with data 1..8 -> wr_addr 0..7 with data 1..8, one start pulse; done -> finish=1, index=8.
REQ-038 Transpose: op=11, 5 presses -> wr_addr 0..3 only, start after 4th element, no B writes.
REQ-039 Timeout: withhold done -> error=1 exactly DONE_TIMEOUT cycles after WAIT entry; press -> IDLE, error=0.
REQ-040 Enter held 50 cycles in LOAD_A -> exactly one wr_en pulse; sw+enter same cycle at count 2 -> no write, IDLE.
REQ-041 done with dp_error=1 -> ERR; reset asserted in WAIT -> all outputs at reset values within same cycle; later done ignored.
REQ-042 SHOW: 4 presses -> rd_addr 0,1,2,3 then IDLE, finish=0, busy=0.
